lsu: RTL and testbench
======================

Name: lsu

Overview:
Load/store unit between the execute stage and the data-memory port of the rv32 core. It accepts one load or store per request handshake and checks func3 legality and address alignment. It drives a word-aligned memory bus with byte enables, waits for a memory acknowledge with a timeout, and aligns and extends load data. It returns a single-cycle response to writeback that carries the destination register and any error cause.

Parameters:
TIMEOUT, 16, number of ACCESS cycles without mem_ack before the access is aborted with a bus-timeout error (legal range 1..255).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  execute stage presents a request
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_read  input  1  load request
req_write  input  1  store request
req_func3  input  3  RV32 load/store func3
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits significant)
req_rd  input  5  load destination register
mem_req  output  1  bus access active
mem_we  output  1  1 = write
mem_addr  output  32  word address, {req_addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  access complete; rdata valid the same cycle
mem_rdata  input  32  read word
rsp_valid  output  1  one-cycle response pulse
rsp_data  output  32  extended load result; 0 for stores and errors
rsp_rd  output  5  echo of req_rd
rsp_we  output  1  register-file write enable
rsp_cause  output  3  0 ok, 1 load misaligned, 2 store misaligned, 3 illegal request, 4 bus timeout

Behaviour:
- All outputs are registered. On reset the FSM enters IDLE and drives req_ready=1 and mem_req=mem_we=0. mem_be, mem_addr, mem_wdata, rsp_data, rsp_rd and rsp_cause are 0. rsp_valid=rsp_we=0.
- States are IDLE, ACCESS and RESP. A request is accepted when req_valid && req_ready && (req_read || req_write) in IDLE. If req_valid is high with neither read nor write set, the request is ignored.
- On acceptance the LSU latches addr, func3, wdata, rd and the direction.
- An illegal request goes to RESP with cause 3. Illegal means both read and write set, load func3 in {011,110,111}, or store func3 outside {000,001,010}.
- A misaligned request goes to RESP with cause 1 for a load or cause 2 for a store. Halfword accesses (func3 001 or 101) are misaligned when addr[0]=1. Word accesses are misaligned when addr[1:0]!=0. No bus access is made for either error.
- Otherwise the FSM enters ACCESS, and mem_req=1 is driven from the next cycle.
- In ACCESS, mem_req stays high and the bus outputs stay stable until mem_ack.
- mem_be is 1111 for loads. For stores it is 0001<<addr[1:0] for sb, 0011<<addr[1:0] for sh, and 1111 for sw.
- mem_wdata is {4{wdata[7:0]}} for sb, {2{wdata[15:0]}} for sh, and wdata for sw.
- When mem_ack is high in ACCESS, the LSU captures mem_rdata, drops mem_req on the next edge and goes to RESP.
- mem_ack outside ACCESS is ignored.
- A wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT, mem_req drops and the FSM goes to RESP with cause 4.
- Load extraction: sh = 8*addr[1:0]. lb is mem_rdata>>sh bits [7:0] sign-extended from bit 7. lbu is the same byte zero-extended. lh is the halfword sign-extended from bit 15. lhu is the halfword zero-extended. lw is mem_rdata unchanged.
- RESP lasts exactly one cycle. rsp_valid=1 and rsp_rd equals the latched rd. rsp_we=1 only for an error-free load with rd!=0. Then the FSM returns to IDLE, and a new request can be accepted in that IDLE cycle.
- Minimum occupancy is 3 cycles per request (accept, ACCESS with immediate ack, RESP). An error response takes 2 cycles.
- Writeback always consumes rsp; there is no backpressure.
- Reset asserted mid-ACCESS or mid-RESP returns the FSM to IDLE at that edge with mem_req=0. No response is emitted for the aborted request.

Test Plan:
- lw at 0x40 with mem_ack on the first ACCESS cycle and rdata 0xDEADBEEF -> mem_addr=0x40, mem_be=1111, rsp_valid 2 cycles after accept, rsp_data=0xDEADBEEF, rsp_we=1, cause 0.
- sb at 0x43 with wdata 0x1234_56A5 -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5A5A5, rsp_we=0, rsp_data=0.
- lb at 0x41 with rdata 0x0000_8000 -> 0xFFFFFF80. lbu at the same address -> 0x00000080. lh at 0x42 with rdata 0x8001_0000 -> 0xFFFF8001. lhu -> 0x00008001.
- lw at 0x42 -> no mem_req, rsp_cause=1, rsp_we=0. sh at 0x45 -> cause 2. func3=011 load -> cause 3. read and write both set -> cause 3.
- With TIMEOUT=4 and mem_ack held low -> mem_req high for exactly 4 cycles, then rsp_cause=4. A later ack is ignored and the next request completes normally.
- Back-to-back requests with req_valid held high -> second accept occurs in the cycle after RESP. rst_n low during ACCESS -> mem_req=0 after that edge, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: request legality/alignment checks, word-aligned memory bus
// access with timeout, load data alignment/extension and writeback response.
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_we,
  output logic [2:0]  rsp_cause
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] CAUSE_OK      = 3'd0;
  localparam logic [2:0] CAUSE_LD_MIS  = 3'd1;
  localparam logic [2:0] CAUSE_ST_MIS  = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             ld_q;
  logic [CNT_W-1:0] cnt;

  logic        accept;
  logic        illegal;
  logic        misal;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  // Request decode: legality, alignment and bus lane formatting
  always_comb begin
    accept  = (state == IDLE) && req_valid && req_ready && (req_read || req_write);
    illegal = (req_read && req_write) ||
              (req_read && ((req_func3 == 3'b011) || (req_func3[2:1] == 2'b11))) ||
              (req_write && (req_func3[2] || (req_func3[1:0] == 2'b11)));
    misal   = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    be_n    = 4'b1111;
    wdata_n = req_wdata;
    if (!req_read) begin
      case (req_func3[1:0])
        2'b00:   begin
          be_n    = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        2'b01:   begin
          be_n    = 4'b0011 << req_addr[1:0];
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  // Load data alignment and extension from the latched offset/func3
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_rd    <= 5'd0;
      rsp_we    <= 1'b0;
      rsp_cause <= CAUSE_OK;
      off_q     <= 2'd0;
      f3_q      <= 3'd0;
      rd_q      <= 5'd0;
      ld_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_we    <= 1'b0;
          if (accept) begin
            off_q     <= req_addr[1:0];
            f3_q      <= req_func3;
            rd_q      <= req_rd;
            ld_q      <= req_read;
            req_ready <= 1'b0;
            if (illegal || misal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'd0;
              rsp_rd    <= req_rd;
              rsp_cause <= illegal ? CAUSE_ILLEGAL :
                           (req_read ? CAUSE_LD_MIS : CAUSE_ST_MIS);
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              cnt       <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= ld_q ? ld_data : 32'd0;
            rsp_rd    <= rd_q;
            rsp_we    <= ld_q && (rd_q != 5'd0);
            rsp_cause <= CAUSE_OK;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_rd    <= rd_q;
            rsp_we    <= 1'b0;
            rsp_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_we    <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu, instantiated with TIMEOUT=4.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read, req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_we;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [2:0]  rsp_cause;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_we(rsp_we), .rsp_cause(rsp_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one IDLE cycle; returns in the cycle after the accept edge
  task automatic send(input logic r, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_read = r; req_write = w;
    req_func3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
  endtask

  // Acknowledge in the current ACCESS cycle; returns in the RESP cycle
  task automatic ack(input logic [31:0] rdata);
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp);
    send(1'b1, 1'b0, f3, a, 32'd0, 5'd9);
    ack(rdata);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, exp);
    @(negedge clk);
  endtask

  task automatic err_chk(input string tag, input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [2:0] cause);
    send(r, w, f3, a, 32'hFFFF_FFFF, 5'd4);
    chk({tag, "_memreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_cause"}, 32'(rsp_cause), 32'(cause));
    chk({tag, "_we"}, 32'(rsp_we), 32'd0);
    chk({tag, "_data"}, rsp_data, 32'd0);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_memwe", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
    chk("rst_cause", 32'(rsp_cause), 32'd0);
    rst_n = 1'b1;

    // lw 0x40, immediate ack
    send(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd7);
    chk("lw_memreq", 32'(mem_req), 32'd1);
    chk("lw_addr", mem_addr, 32'h40);
    chk("lw_be", 32'(mem_be), 32'hF);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_early_valid", 32'(rsp_valid), 32'd0);
    ack(32'hDEAD_BEEF);
    chk("lw_valid", 32'(rsp_valid), 32'd1);
    chk("lw_data", rsp_data, 32'hDEAD_BEEF);
    chk("lw_rspwe", 32'(rsp_we), 32'd1);
    chk("lw_rd", 32'(rsp_rd), 32'd7);
    chk("lw_cause", 32'(rsp_cause), 32'd0);
    chk("lw_memreq_off", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("lw_pulse", 32'(rsp_valid), 32'd0);
    chk("lw_ready", 32'(req_ready), 32'd1);

    // sb 0x43
    send(1'b0, 1'b1, 3'b000, 32'h43, 32'h1234_56A5, 5'd2);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr, 32'h40);
    ack(32'hFFFF_FFFF);
    chk("sb_valid", 32'(rsp_valid), 32'd1);
    chk("sb_rspwe", 32'(rsp_we), 32'd0);
    chk("sb_data", rsp_data, 32'd0);
    @(negedge clk);

    // sh 0x42
    send(1'b0, 1'b1, 3'b001, 32'h42, 32'hCAFE_1357, 5'd2);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'h1357_1357);
    ack(32'd0);
    @(negedge clk);

    load_chk("lb", 3'b000, 32'h41, 32'h0000_8000, 32'hFFFF_FF80);
    load_chk("lbu", 3'b100, 32'h41, 32'h0000_8000, 32'h0000_0080);
    load_chk("lh", 3'b001, 32'h42, 32'h8001_0000, 32'hFFFF_8001);
    load_chk("lhu", 3'b101, 32'h42, 32'h8001_0000, 32'h0000_8001);

    // lw to x0 never writes the register file
    send(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd0);
    ack(32'h1111_2222);
    chk("x0_rspwe", 32'(rsp_we), 32'd0);
    @(negedge clk);

    err_chk("lw_mis", 1'b1, 1'b0, 3'b010, 32'h42, 3'd1);
    err_chk("sh_mis", 1'b0, 1'b1, 3'b001, 32'h45, 3'd2);
    err_chk("ld011", 1'b1, 1'b0, 3'b011, 32'h40, 3'd3);
    err_chk("rdwr", 1'b1, 1'b1, 3'b010, 32'h40, 3'd3);
    err_chk("st100", 1'b0, 1'b1, 3'b100, 32'h40, 3'd3);

    // Neither read nor write: ignored
    @(negedge clk);
    req_valid = 1'b1; req_func3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    chk("noop_ready", 32'(req_ready), 32'd1);
    chk("noop_memreq", 32'(mem_req), 32'd0);
    chk("noop_valid", 32'(rsp_valid), 32'd0);

    // Timeout after 4 ACCESS cycles
    send(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 5'd5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_memreq%0d", i), 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    chk("to_memreq_off", 32'(mem_req), 32'd0);
    chk("to_valid", 32'(rsp_valid), 32'd1);
    chk("to_cause", 32'(rsp_cause), 32'd4);
    chk("to_rspwe", 32'(rsp_we), 32'd0);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_valid", 32'(rsp_valid), 32'd0);
    chk("late_ack_ready", 32'(req_ready), 32'd1);
    load_chk("after_to", 3'b010, 32'h84, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_func3 = 3'b010; req_addr = 32'h40; req_rd = 5'd3;
    @(negedge clk);
    chk("b2b_acc1", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
    chk("b2b_ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b_ready_idle", 32'(req_ready), 32'd1);
    chk("b2b_idle_memreq", 32'(mem_req), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_read = 1'b0;
    chk("b2b_acc2", 32'(mem_req), 32'd1);
    chk("b2b_ready_acc2", 32'(req_ready), 32'd0);
    ack(32'h0);
    chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
    @(negedge clk);

    // Reset during ACCESS
    send(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd6);
    chk("rstacc_memreq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstacc_memreq_off", 32'(mem_req), 32'd0);
    chk("rstacc_valid", 32'(rsp_valid), 32'd0);
    chk("rstacc_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rstacc_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rstacc_idle_memreq", 32'(mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
